xyz_rx_serializer: RTL

Consumer-side end of the x/y/z three-field interface that module M drives as producer. Accepts one {x,y,z} triple per valid/ready handshake and buffers triples in a small FIFO. Re-emits each triple as three consecutive WIDTH-bit beats, x then y then z, on a single valid/ready byte stream. Sits between the interface consumer modport and the downstream byte sink in top, replacing the direct o_a/o_b/o_c fan-out.

---
 rtl/xyz_rx_serializer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/xyz_rx_serializer.sv
// Accepts {x,y,z} triples into a small FIFO and replays each one as three
// WIDTH-bit beats (x, y, z) on a single valid/ready stream.
//
// state | meaning
// SEL_X | head triple's x beat is presented (idle state when empty)
// SEL_Y | head triple's y beat is presented
// SEL_Z | head triple's z beat is presented; acceptance pops the head
module xyz_rx_serializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [0:WIDTH-1]         i_x,
   input  logic [0:WIDTH-1]         i_y,
   input  logic [0:WIDTH-1]         i_z,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_valid,
   output logic                     o_last,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [CNT_W-1:0]         o_frame_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      SEL_X = 2'd0,
      SEL_Y = 2'd1,
      SEL_Z = 2'd2
   } sel_e;

   logic [WIDTH-1:0] mem_x_q [DEPTH];
   logic [WIDTH-1:0] mem_y_q [DEPTH];
   logic [WIDTH-1:0] mem_z_q [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   sel_e             state_q, state_d;

   logic [WIDTH-1:0] x_map, y_map, z_map;
   logic             push, pop, beat_acc;

   // Inputs are ascending-indexed; keep bit i on bit i rather than by position.
   always_comb begin
      x_map = '0;
      y_map = '0;
      z_map = '0;
      for (int i = 0; i < WIDTH; i++) begin
         x_map[i] = i_x[i];
         y_map[i] = i_y[i];
         z_map[i] = i_z[i];
      end
   end

   assign o_ready  = (level_q != LW'(DEPTH));
   assign o_valid  = (level_q != '0);
   assign push     = i_valid && o_ready;
   assign beat_acc = o_valid && i_ready;
   assign pop      = beat_acc && (state_q == SEL_Z);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      if (push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
         cnt_d  = cnt_q + CNT_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_x_q[i] <= '0;
            mem_y_q[i] <= '0;
            mem_z_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         if (push) begin
            mem_x_q[wptr_q] <= x_map;
            mem_y_q[wptr_q] <= y_map;
            mem_z_q[wptr_q] <= z_map;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= SEL_X;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      o_data  = mem_x_q[rptr_q];
      case (state_q)
         SEL_X: begin
            o_data = mem_x_q[rptr_q];
            if (beat_acc) state_d = SEL_Y;
         end
         SEL_Y: begin
            o_data = mem_y_q[rptr_q];
            if (beat_acc) state_d = SEL_Z;
         end
         SEL_Z: begin
            o_data = mem_z_q[rptr_q];
            if (beat_acc) state_d = SEL_X;
         end
         default: state_d = SEL_X;
      endcase
   end

   assign o_last      = o_valid && (state_q == SEL_Z);
   assign o_level     = level_q;
   assign o_frame_cnt = cnt_q;

endmodule
